line_fetch_server: RTL and testbench

- Responder side of the scaler line-fetch handshake.
- Accepts a fetch_en/fetch_line request from scale_down_bilinear and reads the two source lines fetch_line and fetch_line+1 (the second clamped to the last line) from the frame-buffer read port.
- Streams the pixels back on wr_ram_en/ram_dat, then pulses fetch_done.
- Sits between scale_down_bilinear and the DDR read path; the frame is laid out by vin_ctrl at address {y, x<<2}.

---
 rtl/scale_pkg.sv | 30 +++
 rtl/rd_credit_cnt.sv | 51 +++++
 rtl/line_fetch_server.sv | 171 +++++++++++++++++
 tb/tb_line_fetch_server.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared types and address helpers for the scaler line-fetch path.
package scale_pkg;

   localparam int PIX_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } fetch_state_t;

   // Frame-buffer byte address of pixel (x, y): line in the upper half, x scaled to bytes below.
   function automatic logic [31:0] pix_addr(input logic [15:0] y, input logic [15:0] x);
      logic [15:0] xb;
      xb = x * 16'(PIX_BYTES);
      return {y, xb};
   endfunction

   // Limit a line index to the last line of the frame; the input is one bit wider so line+1 cannot wrap.
   function automatic logic [15:0] clamp_line(input logic [16:0] line, input logic [15:0] yres);
      logic [15:0] last;
      last = (yres == 16'd0) ? 16'd0 : yres - 16'd1;
      if (line > {1'b0, last}) begin
         return last;
      end
      return line[15:0];
   endfunction

endpackage

// File: rtl/rd_credit_cnt.sv
// Tracks memory reads in flight and, after a frame restart, the reads still owed
// by the memory that must be swallowed before a new fetch may start.
module rd_credit_cnt #(
   parameter int MAX_OUT = 4
) (
   input  logic vin_clk,
   input  logic rst,
   input  logic abort,
   input  logic req_fire,
   input  logic rtn,
   output logic can_issue,
   output logic drop,
   output logic rtn_live,
   output logic rtn_spurious
);

   localparam int CW = $clog2(MAX_OUT + 1);

   logic [CW-1:0] out_cnt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] out_nx;
   logic [CW-1:0] drop_nx;
   logic          rtn_drop;

   assign drop         = (drop_cnt != '0);
   assign can_issue    = (out_cnt < CW'(MAX_OUT));
   assign rtn_live     = rtn && (out_cnt != '0) && !drop;
   assign rtn_drop     = rtn && drop;
   assign rtn_spurious = rtn && (out_cnt == '0) && !drop;

   // Next in-flight count, and the total still owed if this cycle is a frame restart.
   always_comb begin
      out_nx  = out_cnt + CW'(req_fire) - CW'(rtn_live);
      drop_nx = drop_cnt - CW'(rtn_drop);
      if (abort) begin
         drop_nx = drop_nx + out_nx;
      end
   end

   // Counter registers; a restart hands every live read over to the drop counter.
   always_ff @(posedge vin_clk or posedge rst) begin
      if (rst) begin
         out_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         out_cnt  <= abort ? '0 : out_nx;
         drop_cnt <= drop_nx;
      end
   end

endmodule

// File: rtl/line_fetch_server.sv
// Responder for the scaler line-fetch handshake: reads a clamped line pair from
// the frame buffer and streams its pixels back in order, then pulses fetch_done.
module line_fetch_server
   import scale_pkg::*;
#(
   parameter int MAX_OUT = 4,
   parameter int DW      = 16,
   parameter int AW      = 32
) (
   input  logic          vin_clk,
   input  logic          rst,
   input  logic          frame_sync_n,
   input  logic [15:0]   vin_xres,
   input  logic [15:0]   vin_yres,
   input  logic          fetch_en,
   input  logic [15:0]   fetch_line,
   output logic          wr_ram_en,
   output logic [DW-1:0] ram_dat,
   output logic          fetch_done,
   output logic          busy,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   input  logic          mem_rd_ready,
   input  logic          mem_rd_valid,
   input  logic [DW-1:0] mem_rd_dat,
   output logic          err
);

   fetch_state_t state;
   fetch_state_t state_next;

   logic [15:0] y0;
   logic [15:0] y1;
   logic [15:0] xres;
   logic [15:0] x;
   logic        line_sel;
   logic [16:0] beat_cnt;
   logic [31:0] cur_addr;

   logic abort;
   logic accept;
   logic req_fire;
   logic x_wrap;
   logic can_issue;
   logic drop;
   logic rtn_live;
   logic rtn_spurious;

   assign abort       = !frame_sync_n;
   assign accept      = (state == IDLE) && fetch_en && !drop && !abort;
   assign mem_rd_en   = (state == ISSUE) && can_issue && !abort;
   assign req_fire    = mem_rd_en && mem_rd_ready;
   assign x_wrap      = (x == xres - 16'd1);
   assign cur_addr    = pix_addr(line_sel ? y1 : y0, x);
   assign mem_rd_addr = (state == ISSUE) ? AW'(cur_addr) : '0;
   assign busy        = (state != IDLE);
   assign fetch_done  = (state == DONE);

   rd_credit_cnt #(
      .MAX_OUT(MAX_OUT)
   ) u_credit (
      .vin_clk     (vin_clk),
      .rst         (rst),
      .abort       (abort),
      .req_fire    (req_fire),
      .rtn         (mem_rd_valid),
      .can_issue   (can_issue),
      .drop        (drop),
      .rtn_live    (rtn_live),
      .rtn_spurious(rtn_spurious)
   );

   // State register.
   always_ff @(posedge vin_clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a frame restart always returns to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (vin_xres == 16'd0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (req_fire && line_sel && x_wrap) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (beat_cnt == {xres, 1'b0}) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (abort) begin
         state_next = IDLE;
      end
   end

   // Request bookkeeping: latch the clamped line pair, walk x across both lines, count beats.
   always_ff @(posedge vin_clk or posedge rst) begin
      if (rst) begin
         y0       <= '0;
         y1       <= '0;
         xres     <= '0;
         x        <= '0;
         line_sel <= 1'b0;
         beat_cnt <= '0;
      end else if (abort) begin
         x        <= '0;
         line_sel <= 1'b0;
         beat_cnt <= '0;
      end else begin
         if (accept) begin
            y0       <= clamp_line({1'b0, fetch_line}, vin_yres);
            y1       <= clamp_line({1'b0, fetch_line} + 17'd1, vin_yres);
            xres     <= vin_xres;
            x        <= '0;
            line_sel <= 1'b0;
            beat_cnt <= '0;
         end
         if (req_fire) begin
            if (x_wrap) begin
               x        <= '0;
               line_sel <= !line_sel;
            end else begin
               x <= x + 16'd1;
            end
         end
         if (rtn_live) begin
            beat_cnt <= beat_cnt + 17'd1;
         end
      end
   end

   // Return path: forward live read data one cycle later and flag returns nobody asked for.
   always_ff @(posedge vin_clk or posedge rst) begin
      if (rst) begin
         wr_ram_en <= 1'b0;
         ram_dat   <= '0;
         err       <= 1'b0;
      end else begin
         if (rtn_spurious) begin
            err <= 1'b1;
         end
         if (abort) begin
            wr_ram_en <= 1'b0;
            ram_dat   <= '0;
         end else begin
            wr_ram_en <= rtn_live;
            if (rtn_live) begin
               ram_dat <= mem_rd_dat;
            end
         end
      end
   end

endmodule

// File: tb/tb_line_fetch_server.sv
// Directed bench for line_fetch_server with an in-order, fixed-latency memory model.
module tb_line_fetch_server;

   localparam int MAX_OUT = 4;
   localparam int DW      = 16;
   localparam int AW      = 32;

   typedef struct packed {
      logic [15:0]      xres;
      logic [15:0]      yres;
      logic [15:0]      line;
      logic [7:0]       lat;
      logic             tog;
      logic [15:0]      y0;
      logic [15:0]      y1;
      logic [7:0]       nbeats;
      logic [0:7][15:0] beats;
   } vec_t;

   logic          vin_clk;
   logic          rst;
   logic          frame_sync_n;
   logic [15:0]   vin_xres;
   logic [15:0]   vin_yres;
   logic          fetch_en;
   logic [15:0]   fetch_line;
   logic          wr_ram_en;
   logic [DW-1:0] ram_dat;
   logic          fetch_done;
   logic          busy;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic          mem_rd_ready;
   logic          mem_rd_valid;
   logic [DW-1:0] mem_rd_dat;
   logic          err;

   int          checks;
   int          errors;
   int          cyc;
   int          lat;
   bit          toggle;
   int          n_iss;
   int          n_ret;
   int          ret_cyc;
   int          beat_cyc;
   int          done_cyc;
   int          done_count;
   bit          stall_prev;
   logic [31:0] stall_addr;
   logic [31:0] addr_log[$];
   logic [15:0] beat_log[$];
   logic [15:0] rq_dat[$];
   int          rq_due[$];
   vec_t        vecs[5];

   line_fetch_server #(
      .MAX_OUT(MAX_OUT),
      .DW     (DW),
      .AW     (AW)
   ) dut (
      .vin_clk     (vin_clk),
      .rst         (rst),
      .frame_sync_n(frame_sync_n),
      .vin_xres    (vin_xres),
      .vin_yres    (vin_yres),
      .fetch_en    (fetch_en),
      .fetch_line  (fetch_line),
      .wr_ram_en   (wr_ram_en),
      .ram_dat     (ram_dat),
      .fetch_done  (fetch_done),
      .busy        (busy),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_ready(mem_rd_ready),
      .mem_rd_valid(mem_rd_valid),
      .mem_rd_dat  (mem_rd_dat),
      .err         (err)
   );

   initial begin
      vin_clk = 1'b0;
      forever #5 vin_clk = !vin_clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: monitor at the falling edge, then update the memory model just after the rising edge.
   task automatic tick();
      logic [31:0] a;
      logic [15:0] d;
      @(negedge vin_clk);
      if (stall_prev) begin
         checkOutput("hold_en", 32'(mem_rd_en), 32'd1);
         checkOutput("hold_addr", 32'(mem_rd_addr), stall_addr);
      end
      stall_prev = mem_rd_en && !mem_rd_ready;
      stall_addr = 32'(mem_rd_addr);
      if (mem_rd_en && mem_rd_ready) begin
         a = 32'(mem_rd_addr);
         d = (a[31:16] << 4) + {2'b00, a[15:2]};
         addr_log.push_back(a);
         rq_dat.push_back(d);
         rq_due.push_back(cyc + lat);
         n_iss++;
         checkOutput("inflight_le_max", 32'((n_iss - n_ret) <= MAX_OUT), 32'd1);
      end
      if (mem_rd_valid && (n_ret < n_iss)) begin
         n_ret++;
         ret_cyc = cyc;
      end
      if (wr_ram_en) begin
         beat_log.push_back(ram_dat);
         beat_cyc = cyc;
      end
      if (fetch_done) begin
         done_count++;
         done_cyc = cyc;
      end
      @(posedge vin_clk);
      #1;
      cyc++;
      mem_rd_valid = 1'b0;
      if ((rq_due.size() > 0) && (rq_due[0] <= cyc)) begin
         mem_rd_valid = 1'b1;
         mem_rd_dat   = rq_dat.pop_front();
         void'(rq_due.pop_front());
      end
      if (toggle) begin
         mem_rd_ready = !mem_rd_ready;
      end
   endtask

   task automatic clearLogs();
      addr_log.delete();
      beat_log.delete();
      done_count = 0;
      done_cyc   = -1;
      beat_cyc   = -1;
   endtask

   task automatic waitDone();
      int k;
      k = 0;
      while ((done_count == 0) && (k < 400)) begin
         tick();
         k++;
      end
      checkOutput("done_seen", 32'(done_count != 0), 32'd1);
      tick();
      tick();
   endtask

   task automatic applyStimulus(input vec_t v);
      lat          = int'(v.lat);
      toggle       = v.tog;
      mem_rd_ready = 1'b1;
      clearLogs();
      vin_xres   = v.xres;
      vin_yres   = v.yres;
      fetch_line = v.line;
      fetch_en   = 1'b1;
      tick();
      fetch_en = 1'b0;
      waitDone();
      toggle       = 1'b0;
      mem_rd_ready = 1'b1;
   endtask

   task automatic checkFetch(input vec_t v);
      int          nb;
      logic [15:0] y;
      logic [15:0] xx;
      logic [31:0] ea;
      nb = int'(v.nbeats);
      checkOutput("beat_count", 32'(beat_log.size()), 32'(nb));
      checkOutput("req_count", 32'(addr_log.size()), 32'(nb));
      for (int i = 0; i < nb; i++) begin
         y  = (i < int'(v.xres)) ? v.y0 : v.y1;
         xx = 16'(i % int'(v.xres));
         ea = {y, xx[13:0], 2'b00};
         if (i < beat_log.size()) begin
            checkOutput($sformatf("beat_data[%0d]", i), 32'(beat_log[i]), 32'(v.beats[i]));
         end
         if (i < addr_log.size()) begin
            checkOutput($sformatf("req_addr[%0d]", i), addr_log[i], ea);
         end
      end
      checkOutput("done_pulses", 32'(done_count), 32'd1);
      checkOutput("done_after_last_beat", 32'(done_cyc - beat_cyc), 32'd1);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
      checkOutput("err_clear", 32'(err), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_wr_ram_en"}, 32'(wr_ram_en), 32'd0);
      checkOutput({tag, "_ram_dat"}, 32'(ram_dat), 32'd0);
      checkOutput({tag, "_fetch_done"}, 32'(fetch_done), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
      checkOutput({tag, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
      checkOutput({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      int k;
      int start;
      checks       = 0;
      errors       = 0;
      cyc          = 0;
      lat          = 2;
      toggle       = 1'b0;
      n_iss        = 0;
      n_ret        = 0;
      ret_cyc      = -1;
      stall_prev   = 1'b0;
      stall_addr   = '0;
      rst          = 1'b1;
      frame_sync_n = 1'b1;
      vin_xres     = '0;
      vin_yres     = '0;
      fetch_en     = 1'b0;
      fetch_line   = '0;
      mem_rd_ready = 1'b1;
      mem_rd_valid = 1'b0;
      mem_rd_dat   = '0;
      clearLogs();

      vecs[0] = '{xres: 16'd4, yres: 16'd4, line: 16'd1, lat: 8'd2, tog: 1'b0, y0: 16'd1, y1: 16'd2, nbeats: 8'd8,
                  beats: {16'd16, 16'd17, 16'd18, 16'd19, 16'd32, 16'd33, 16'd34, 16'd35}};
      vecs[1] = '{xres: 16'd4, yres: 16'd4, line: 16'd3, lat: 8'd2, tog: 1'b0, y0: 16'd3, y1: 16'd3, nbeats: 8'd8,
                  beats: {16'd48, 16'd49, 16'd50, 16'd51, 16'd48, 16'd49, 16'd50, 16'd51}};
      vecs[2] = '{xres: 16'd4, yres: 16'd4, line: 16'd1, lat: 8'd10, tog: 1'b1, y0: 16'd1, y1: 16'd2, nbeats: 8'd8,
                  beats: {16'd16, 16'd17, 16'd18, 16'd19, 16'd32, 16'd33, 16'd34, 16'd35}};
      vecs[3] = '{xres: 16'd2, yres: 16'd8, line: 16'd5, lat: 8'd1, tog: 1'b0, y0: 16'd5, y1: 16'd6, nbeats: 8'd4,
                  beats: {16'd80, 16'd81, 16'd96, 16'd97, 16'd0, 16'd0, 16'd0, 16'd0}};
      vecs[4] = '{xres: 16'd3, yres: 16'd4, line: 16'd7, lat: 8'd3, tog: 1'b1, y0: 16'd3, y1: 16'd3, nbeats: 8'd6,
                  beats: {16'd48, 16'd49, 16'd50, 16'd48, 16'd49, 16'd50, 16'd0, 16'd0}};

      #1;
      checkAllZero("reset");
      @(posedge vin_clk);
      #1;
      rst = 1'b0;
      tick();
      checkAllZero("post_reset");

      $display("[TB] table-driven fetches");
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v]);
         checkFetch(vecs[v]);
      end

      $display("[TB] frame restart with three reads in flight");
      lat = 6;
      clearLogs();
      vin_xres   = 16'd4;
      vin_yres   = 16'd4;
      fetch_line = 16'd1;
      fetch_en   = 1'b1;
      tick();
      fetch_en = 1'b0;
      start    = n_iss;
      k = 0;
      while (((n_iss - start) < 3) && (k < 20)) begin
         tick();
         k++;
      end
      checkOutput("abort_inflight", 32'(n_iss - start), 32'd3);
      frame_sync_n = 1'b0;
      fetch_en     = 1'b1;
      tick();
      frame_sync_n = 1'b1;
      checkOutput("abort_no_req", 32'(n_iss - start), 32'd3);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      k = 0;
      while (!busy && (k < 40)) begin
         tick();
         k++;
      end
      checkOutput("reaccept_busy", 32'(busy), 32'd1);
      checkOutput("reaccept_after_drop", 32'(cyc - ret_cyc), 32'd2);
      checkOutput("dropped_returns", 32'(n_ret - start), 32'd3);
      checkOutput("dropped_no_beats", 32'(beat_log.size()), 32'd0);
      fetch_en = 1'b0;
      clearLogs();
      waitDone();
      checkFetch(vecs[0]);

      $display("[TB] zero-width request");
      clearLogs();
      vin_xres = 16'd0;
      fetch_en = 1'b1;
      start    = cyc;
      tick();
      fetch_en = 1'b0;
      tick();
      tick();
      checkOutput("xres0_done_pulses", 32'(done_count), 32'd1);
      checkOutput("xres0_done_cycle", 32'(done_cyc - start), 32'd1);
      checkOutput("xres0_no_reads", 32'(addr_log.size()), 32'd0);

      $display("[TB] spurious return, sticky err, async reset");
      clearLogs();
      mem_rd_valid = 1'b1;
      mem_rd_dat   = 16'hABCD;
      tick();
      tick();
      checkOutput("spurious_err", 32'(err), 32'd1);
      checkOutput("spurious_no_beat", 32'(beat_log.size()), 32'd0);
      frame_sync_n = 1'b0;
      tick();
      frame_sync_n = 1'b1;
      tick();
      checkOutput("err_survives_sync", 32'(err), 32'd1);
      lat = 2;
      clearLogs();
      vin_xres   = 16'd4;
      vin_yres   = 16'd4;
      fetch_line = 16'd1;
      fetch_en   = 1'b1;
      tick();
      fetch_en = 1'b0;
      k = 0;
      while ((beat_log.size() < 2) && (k < 30)) begin
         tick();
         k++;
      end
      checkOutput("mid_issue_busy", 32'(busy), 32'd1);
      checkOutput("err_sticky_busy", 32'(err), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkAllZero("async_rst");
      rst          = 1'b0;
      mem_rd_valid = 1'b0;
      rq_dat.delete();
      rq_due.delete();
      n_iss      = 0;
      n_ret      = 0;
      stall_prev = 1'b0;
      clearLogs();
      repeat (4) tick();
      checkOutput("post_rst_no_beats", 32'(beat_log.size()), 32'd0);
      checkOutput("post_rst_err", 32'(err), 32'd0);
      applyStimulus(vecs[3]);
      checkFetch(vecs[3]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
